// File: rtl/acl_pkg.sv
// -----------------------------------------------------------------------------
// acl_pkg
// Shared definitions for the ACL packet FIFO transmit read-side engine.
//   acl_tx_state_t : read engine FSM state (IDLE, STREAM, DROP)
//   ACL_DATA_WIDTH : default FIFO / transmit data width
//   ACL_SKID_DEPTH : number of entries in the transmit skid buffer
// -----------------------------------------------------------------------------
package acl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DROP   = 2'd2
  } acl_tx_state_t;

  localparam int ACL_DATA_WIDTH = 8;
  localparam int ACL_SKID_DEPTH = 2;

endpackage

// File: rtl/acl_tx_skid_buf.sv
// -----------------------------------------------------------------------------
// acl_tx_skid_buf
// Two-entry valid/ready register buffer carrying {last, data} in FIFO order.
// The head entry drives the output directly from flops, so the output word is
// held stable while the consumer stalls. Unused entries are kept at zero, which
// makes the output data and last flag read 0 whenever the buffer is empty.
//
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   i_push         : write i_data/i_last this cycle (caller guarantees a slot)
//   i_data, i_last : word being written
//   o_slot_free    : a push this cycle would fit (includes same-cycle drain)
//   o_valid        : head entry holds a word
//   o_data, o_last : head entry contents (zero when o_valid = 0)
//   i_ready        : consumer accepts the head entry
// -----------------------------------------------------------------------------
module acl_tx_skid_buf
  import acl_pkg::*;
#(
  parameter int DATA_WIDTH = ACL_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  output logic                  o_slot_free,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  input  logic                  i_ready
);

  localparam logic [1:0] SkidFull = 2'(ACL_SKID_DEPTH);

  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic                  head_last_q, head_last_d;
  logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
  logic                  tail_last_q, tail_last_d;
  logic [1:0]            count_q, count_d;
  logic                  pop;

  assign o_valid     = (count_q != 2'd0);
  assign o_data      = head_data_q;
  assign o_last      = head_last_q;
  assign pop         = o_valid & i_ready;
  // A word leaving on this edge frees its slot for the word arriving.
  assign o_slot_free = (count_q < SkidFull) | pop;

  always_comb begin
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    count_d     = count_q;
    case ({i_push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_data_d = i_data;
          head_last_d = i_last;
        end else begin
          tail_data_d = i_data;
          tail_last_d = i_last;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // Shift forward; the tail is always zero when unused, so draining the
        // last word leaves the head zeroed as well.
        head_data_d = tail_data_q;
        head_last_d = tail_last_q;
        tail_data_d = '0;
        tail_last_d = 1'b0;
        count_d     = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_data_d = i_data;
          head_last_d = i_last;
        end else begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          tail_data_d = i_data;
          tail_last_d = i_last;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: rtl/acl_txd_fifo_reader.sv
// -----------------------------------------------------------------------------
// acl_txd_fifo_reader
// Read-side engine of the ACL packet FIFO. Waits for the per-frame ACL verdict
// of the frame at the FIFO head, then either streams the frame out on the
// AXI-Stream transmit port (through a two-entry skid buffer) or pops and
// discards it. Sustains one word per cycle in both modes.
//
// Optional feature macro: ACL_TX_STATS_EN adds forwarded/dropped frame
// counters (o_pkt_fwd_cnt, o_pkt_drop_cnt), counted on the last-word pop.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   i_fifo_data/last/empty   : first-word-fall-through FIFO head
//   o_rd_valid               : pop strobe, head consumed on this edge
//   i_verdict_valid          : verdict available for the head frame
//   i_fifo_invalid           : verdict, 1 = drop, 0 = forward
//   o_verdict_ready          : verdict consumed this cycle
//   o_txd_tdata/tvalid/tlast : transmit stream (zeroed when not valid)
//   i_txd_tready             : downstream accepts the transmit word
//   o_pkt_fwd_cnt/drop_cnt   : frame counters (ACL_TX_STATS_EN only)
// -----------------------------------------------------------------------------
module acl_txd_fifo_reader
  import acl_pkg::*;
#(
  parameter int DATA_WIDTH = ACL_DATA_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_last,
  input  logic                  i_fifo_empty,
  output logic                  o_rd_valid,
  input  logic                  i_verdict_valid,
  input  logic                  i_fifo_invalid,
  output logic                  o_verdict_ready,
  output logic [DATA_WIDTH-1:0] o_txd_tdata,
  output logic                  o_txd_tvalid,
  output logic                  o_txd_tlast,
  input  logic                  i_txd_tready
`ifdef ACL_TX_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  o_pkt_fwd_cnt,
  output logic [CNT_WIDTH-1:0]  o_pkt_drop_cnt
`endif
);

  acl_tx_state_t state_q, state_d;
  logic          rd_valid;
  logic          verdict_ready;
  logic          skid_push;
  logic          slot_free;

  // Pop and verdict strobes depend on the current FIFO head, so they are
  // decoded from the registered state in the same cycle. The next verdict can
  // only be taken once the last word has been popped and the FSM is back in
  // IDLE, which keeps frames from interleaving in the skid buffer.
  always_comb begin
    state_d       = state_q;
    rd_valid      = 1'b0;
    verdict_ready = 1'b0;
    skid_push     = 1'b0;
    case (state_q)
      IDLE: begin
        verdict_ready = i_verdict_valid & ~i_fifo_empty;
        if (verdict_ready) begin
          state_d = i_fifo_invalid ? DROP : STREAM;
        end
      end
      STREAM: begin
        rd_valid  = ~i_fifo_empty & slot_free;
        skid_push = rd_valid;
        if (rd_valid && i_fifo_last) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        rd_valid = ~i_fifo_empty;
        if (rd_valid && i_fifo_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes are forced low while reset is held so that an abandoned frame
  // cannot pop or handshake before reset is released.
  assign o_rd_valid      = rd_valid & rst;
  assign o_verdict_ready = verdict_ready & rst;

  acl_tx_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .i_push     (skid_push),
    .i_data     (i_fifo_data),
    .i_last     (i_fifo_last),
    .o_slot_free(slot_free),
    .o_valid    (o_txd_tvalid),
    .o_data     (o_txd_tdata),
    .o_last     (o_txd_tlast),
    .i_ready    (i_txd_tready)
  );

`ifdef ACL_TX_STATS_EN
  logic [CNT_WIDTH-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // A frame is counted when its last word leaves the FIFO; counters wrap.
  always_comb begin
    fwd_cnt_d  = fwd_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (rd_valid && i_fifo_last) begin
      if (state_q == STREAM) begin
        fwd_cnt_d = fwd_cnt_q + CNT_WIDTH'(1);
      end
      if (state_q == DROP) begin
        drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fwd_cnt_q  <= fwd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_pkt_fwd_cnt  = fwd_cnt_q;
  assign o_pkt_drop_cnt = drop_cnt_q;
`else
  // Without statistics CNT_WIDTH sizes nothing; this empty block only keeps
  // the parameter referenced so both builds share one parameter list.
  if (CNT_WIDTH < 1) begin : g_cnt_width_unused
  end
`endif

endmodule

// File: tb/tb_acl_txd_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_acl_txd_fifo_reader
// Bench for acl_txd_fifo_reader. The FIFO, the verdict source and the
// downstream sink are modelled with queues: every loaded frame with a forward
// verdict is appended to the expected transmit stream, and the bench tracks
// how many forwarded words have been popped but not yet transmitted. Directed
// scenarios (reset, forward, drop, backpressure, underrun, mid-frame reset,
// statistics) are followed by a randomized run. Honours ACL_TX_STATS_EN.
// -----------------------------------------------------------------------------
module tb_acl_txd_fifo_reader;

  localparam int DW = 8;
  localparam int CW = 32;

  logic          clk;
  logic          rst;
  logic [DW-1:0] i_fifo_data;
  logic          i_fifo_last;
  logic          i_fifo_empty;
  logic          o_rd_valid;
  logic          i_verdict_valid;
  logic          i_fifo_invalid;
  logic          o_verdict_ready;
  logic [DW-1:0] o_txd_tdata;
  logic          o_txd_tvalid;
  logic          o_txd_tlast;
  logic          i_txd_tready;
`ifdef ACL_TX_STATS_EN
  logic [CW-1:0] o_pkt_fwd_cnt;
  logic [CW-1:0] o_pkt_drop_cnt;
`endif

  acl_txd_fifo_reader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_fifo_data    (i_fifo_data),
    .i_fifo_last    (i_fifo_last),
    .i_fifo_empty   (i_fifo_empty),
    .o_rd_valid     (o_rd_valid),
    .i_verdict_valid(i_verdict_valid),
    .i_fifo_invalid (i_fifo_invalid),
    .o_verdict_ready(o_verdict_ready),
    .o_txd_tdata    (o_txd_tdata),
    .o_txd_tvalid   (o_txd_tvalid),
    .o_txd_tlast    (o_txd_tlast),
    .i_txd_tready   (i_txd_tready)
`ifdef ACL_TX_STATS_EN
    ,
    .o_pkt_fwd_cnt  (o_pkt_fwd_cnt),
    .o_pkt_drop_cnt (o_pkt_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: FIFO contents {last,data}, pending verdicts, verdict of the
  // frame currently being popped, expected transmit words.
  logic [DW:0] fifoQ[$];
  bit          verdictQ[$];
  bit          acceptedQ[$];
  logic [DW:0] expQ[$];
  bit          readyScript[$];
  bit          holdScript[$];
  int          readyPct = 100;
  int          verdictPct = 100;
  int          holdPct = 0;
  int          inFlight = 0;
  int          fwdFrames = 0;
  int          dropFrames = 0;
  bit          prevStall = 1'b0;
  logic [DW:0] prevWord;
  int          totalChecks = 0;
  int          badChecks = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushWord(input logic [DW-1:0] d, input bit last, input bit drop);
    fifoQ.push_back({last, d});
    if (!drop) expQ.push_back({last, d});
  endtask

  // Loads a frame of up to four bytes, first byte in the most significant lane.
  task automatic loadBytes(input logic [31:0] bytesIn, input int len, input bit drop);
    for (int i = 0; i < len; i++) pushWord(bytesIn[8*(len-1-i) +: 8], i == len - 1, drop);
    verdictQ.push_back(drop);
  endtask

  task automatic loadRandomFrame();
    int len;
    bit drop;
    len  = $urandom_range(6, 1);
    drop = 1'($urandom_range(1));
    for (int i = 0; i < len; i++) pushWord(DW'($urandom), i == len - 1, drop);
    verdictQ.push_back(drop);
  endtask

  task automatic resetModel();
    fifoQ.delete();
    verdictQ.delete();
    acceptedQ.delete();
    expQ.delete();
    readyScript.delete();
    holdScript.delete();
    inFlight   = 0;
    fwdFrames  = 0;
    dropFrames = 0;
    prevStall  = 1'b0;
  endtask

  function automatic bit modelIdle();
    return fifoQ.size() == 0 && verdictQ.size() == 0 && acceptedQ.size() == 0 &&
           inFlight == 0 && expQ.size() == 0;
  endfunction

  // Drives the FIFO head, verdict and tready for the coming cycle. An empty
  // FIFO presents garbage on data/last, which the DUT must ignore.
  task automatic applyStimulus();
    bit hold;
    hold = (holdScript.size() > 0) ? holdScript.pop_front() : ($urandom_range(99) < holdPct);
    i_fifo_empty = hold || (fifoQ.size() == 0);
    if (!i_fifo_empty) begin
      {i_fifo_last, i_fifo_data} = fifoQ[0];
    end else begin
      i_fifo_last = 1'($urandom_range(1));
      i_fifo_data = DW'($urandom);
    end
    i_verdict_valid = (verdictQ.size() > 0) && ($urandom_range(99) < verdictPct);
    i_fifo_invalid  = i_verdict_valid ? verdictQ[0] : 1'($urandom_range(1));
    i_txd_tready    = (readyScript.size() > 0) ? readyScript.pop_front()
                                               : ($urandom_range(99) < readyPct);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rd_valid"}, o_rd_valid, 0);
    checkOutput({tag, " verdict_ready"}, o_verdict_ready, 0);
    checkOutput({tag, " tvalid"}, o_txd_tvalid, 0);
    checkOutput({tag, " tdata"}, o_txd_tdata, 0);
    checkOutput({tag, " tlast"}, o_txd_tlast, 0);
`ifdef ACL_TX_STATS_EN
    checkOutput({tag, " fwd_cnt"}, o_pkt_fwd_cnt, 0);
    checkOutput({tag, " drop_cnt"}, o_pkt_drop_cnt, 0);
`endif
  endtask

  task automatic checkStats(input string tag);
`ifdef ACL_TX_STATS_EN
    checkOutput({tag, " fwd_cnt"}, o_pkt_fwd_cnt, fwdFrames);
    checkOutput({tag, " drop_cnt"}, o_pkt_drop_cnt, dropFrames);
`else
    checkOutput({tag, " tvalid idle"}, o_txd_tvalid, 0);
`endif
  endtask

  // One clock: drive, check the DUT at the falling edge against the model,
  // then advance the model by the events that happen on the rising edge.
  task automatic runCycle();
    bit pop, vr, tx, inProg, curDrop, expPop;
    logic [DW:0] word;
    applyStimulus();
    @(negedge clk);
    pop     = o_rd_valid;
    vr      = o_verdict_ready;
    tx      = o_txd_tvalid && i_txd_tready;
    inProg  = acceptedQ.size() > 0;
    curDrop = inProg ? acceptedQ[0] : 1'b0;
    checkOutput("verdict_ready", vr, !inProg && i_verdict_valid && !i_fifo_empty);
    if (!inProg) expPop = 1'b0;
    else if (curDrop) expPop = !i_fifo_empty;
    else expPop = !i_fifo_empty && (inFlight < 2 || tx);
    checkOutput("rd_valid", pop, expPop);
    checkOutput("tvalid", o_txd_tvalid, inFlight > 0);
    if (!o_txd_tvalid) begin
      checkOutput("idle tdata", o_txd_tdata, 0);
      checkOutput("idle tlast", o_txd_tlast, 0);
    end
    if (prevStall) checkOutput("held word", {o_txd_tlast, o_txd_tdata}, prevWord);
    if (tx) begin
      checkOutput("tx pending", expQ.size() > 0, 1);
      if (expQ.size() > 0) checkOutput("tx word", {o_txd_tlast, o_txd_tdata}, expQ.pop_front());
    end
    prevStall = o_txd_tvalid && !i_txd_tready;
    prevWord  = {o_txd_tlast, o_txd_tdata};
    @(posedge clk);
    #1;
    if (vr && verdictQ.size() > 0) acceptedQ.push_back(verdictQ.pop_front());
    if (pop && !i_fifo_empty && fifoQ.size() > 0) begin
      word = fifoQ.pop_front();
      if (inProg && !curDrop) inFlight++;
      if (inProg && word[DW]) begin
        void'(acceptedQ.pop_front());
        if (curDrop) dropFrames++;
        else fwdFrames++;
      end
    end
    if (tx && inFlight > 0) inFlight--;
  endtask

  task automatic runUntilDrained(input string tag, input int maxCycles);
    int n;
    n = 0;
    while (!modelIdle() && n < maxCycles) begin
      runCycle();
      n++;
    end
    checkOutput({tag, " drained"}, modelIdle(), 1);
  endtask

  initial begin
    rst             = 1'b1;
    i_fifo_data     = '0;
    i_fifo_last     = 1'b0;
    i_fifo_empty    = 1'b1;
    i_verdict_valid = 1'b0;
    i_fifo_invalid  = 1'b0;
    i_txd_tready    = 1'b1;
    #2 rst = 1'b0;

    // Reset held with a frame and its verdict waiting: nothing may move.
    loadBytes(32'h112233, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      @(negedge clk);
      checkAllZero("in reset");
      @(posedge clk);
      #1;
    end
    rst = 1'b1;

    // Forward: no activity until the verdict shows up, then full rate.
    verdictPct = 0;
    for (int i = 0; i < 3; i++) runCycle();
    verdictPct = 100;
    runUntilDrained("forward", 200);

    // Drop followed by a forwarded single-word frame.
    loadBytes(32'hAABB, 2, 1'b1);
    loadBytes(32'h44, 1, 1'b0);
    runUntilDrained("drop", 200);

    // Backpressure for three cycles after the first word.
    loadBytes(32'h01020304, 4, 1'b0);
    readyScript = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    runUntilDrained("backpressure", 200);

    // Underrun after the second word, refill afterwards.
    loadBytes(32'h51525354, 4, 1'b0);
    holdScript = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    runUntilDrained("underrun", 200);
    checkStats("directed");

    // Reset while the third word is at the FIFO head.
    loadBytes(32'h61626364, 4, 1'b0);
    for (int i = 0; i < 3; i++) runCycle();
    rst = 1'b0;
    #1;
    checkAllZero("mid-frame reset");
    @(posedge clk);
    #1;
    resetModel();
    rst = 1'b1;
    loadBytes(32'h77, 1, 1'b0);
    runUntilDrained("after reset", 200);

    // Statistics: three forwarded and two dropped frames.
    readyPct = 70;
    loadBytes(32'h0A0B, 2, 1'b0);
    loadBytes(32'h0C, 1, 1'b1);
    loadBytes(32'h0D0E0F, 3, 1'b0);
    loadBytes(32'h1011, 2, 1'b1);
    loadBytes(32'h12, 1, 1'b0);
    runUntilDrained("stats", 300);
    checkStats("stats");

    // Randomized traffic with backpressure, underruns and late verdicts.
    readyPct   = 60;
    verdictPct = 70;
    holdPct    = 20;
    for (int i = 0; i < 30; i++) loadRandomFrame();
    runUntilDrained("random", 5000);
    checkStats("random");

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
